board_load_ctrl: RTL and testbench

- Sits between the byte parser and the solver.
- Takes the parser's 16-bit line words (header + option bitmaps) and packs option bitmaps contiguously into a single-port option BRAM.
- Builds a per-line index table (base address, option count), then hands the board to the solver with a start pulse.
- During solving, it owns the BRAM port and translates solver (line, option) read requests into BRAM addresses with a fixed-latency return.

---
 rtl/board_pkg.sv | 35 +++
 rtl/board_index_table.sv | 43 ++++
 rtl/board_load_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_board_load_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the board loader: sizes, parser word layout,
// controller states and the per-line index entry.
package board_pkg;

    localparam int MAX_LINES     = 22;   // rows + columns of an 11x11 board
    localparam int BITMAP_W      = 11;   // option bitmap width
    localparam int LINE_IDX_W    = 5;    // line index width
    localparam int ENTRY_BASE_W  = 12;   // base address width of an index entry
    localparam int ENTRY_CNT_W   = 10;   // option count width of an index entry

    // Parser word layout
    localparam int WORD_W        = 16;
    localparam int WORD_HDR_BIT  = 15;   // 1 = header, 0 = option bitmap
    localparam int WORD_IDX_MSB  = 14;   // header: line index
    localparam int WORD_IDX_LSB  = 10;
    localparam int WORD_CNT_MSB  = 9;    // header: expected option count [9:0]

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        SOLVE = 2'd3
    } state_t;

    // One line of the index: where its options start and how many there are.
    typedef struct packed {
        logic [ENTRY_BASE_W-1:0] base;
        logic [ENTRY_CNT_W-1:0]  cnt;
    } index_entry_t;

    function automatic logic [LINE_IDX_W-1:0] word_line_idx(input logic [WORD_W-1:0] w);
        return w[WORD_IDX_MSB:WORD_IDX_LSB];
    endfunction

endpackage

// File: rtl/board_index_table.sv
// Per-line index register file: one synchronous write port, one
// combinational read port, bulk clear. Indices past DEPTH read as zero.
module board_index_table
    import board_pkg::*;
#(
    parameter int DEPTH = MAX_LINES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [LINE_IDX_W-1:0] waddr,
    input  index_entry_t          wdata,
    input  logic [LINE_IDX_W-1:0] raddr,
    output index_entry_t          rdata
);

    index_entry_t entry_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        index_entry_t entry_reg;

        // Hold one line's entry; cleared on reset and when a board is released
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                entry_reg <= '0;
            end else if (we && (waddr == LINE_IDX_W'(gi))) begin
                entry_reg <= wdata;
            end
        end

        assign entry_q[gi] = entry_reg;
    end

    // Combinational lookup; unmapped line numbers report an empty line
    always_comb begin
        rdata = '0;
        if (raddr < LINE_IDX_W'(DEPTH)) begin
            rdata = entry_q[raddr];
        end
    end

endmodule

// File: rtl/board_load_ctrl.sv
// Board loader: packs parser option bitmaps into the option BRAM, builds
// the per-line index, starts the solver and serves its (line, option) reads
// with a fixed BRAM_LAT-cycle return.
// Optional build macro LOAD_CHECK_EN adds consistency checks to load_err
// (count mismatch, line total mismatch, stray option in IDLE, repeated line).
module board_load_ctrl #(
    parameter int MAX_LINES = board_pkg::MAX_LINES,
    parameter int ADDR_W    = board_pkg::ENTRY_BASE_W,
    parameter int CNT_W     = board_pkg::ENTRY_CNT_W,
    parameter int BRAM_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [15:0]       word,
    input  logic              board_done,
    input  logic [3:0]        n,
    input  logic [3:0]        m,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [15:0]       bram_din,
    output logic              bram_we,
    input  logic [15:0]       bram_dout,
    output logic              solve_start,
    input  logic              solve_done,
    input  logic              rd_req,
    input  logic [4:0]        rd_line,
    input  logic [CNT_W-1:0]  rd_opt,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [10:0]       rd_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic              rd_oob,
    output logic [1:0]        state,
    output logic              load_err
);
    import board_pkg::*;

    localparam logic [LINE_IDX_W-1:0] LINES_LIM = LINE_IDX_W'(MAX_LINES);

    state_t                  state_reg, state_next;
    logic [ADDR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic                    full_reg, full_next;       // last BRAM word written
    logic                    open_reg, open_next;       // a valid line is being filled
    logic [LINE_IDX_W-1:0]   cur_idx_reg, cur_idx_next;
    logic [ADDR_W-1:0]       cur_base_reg, cur_base_next;
    logic [CNT_W-1:0]        cur_cnt_reg, cur_cnt_next;
    logic [LINE_IDX_W-1:0]   nm_reg, nm_next;           // n + m of the loaded board
    logic                    err_reg, err_next;
`ifdef LOAD_CHECK_EN
    logic [CNT_W-1:0]        exp_reg, exp_next;
    logic [MAX_LINES-1:0]    seen_reg, seen_next;
    logic [LINE_IDX_W-1:0]   lines_reg, lines_next;
`endif

    logic                    take_header, take_option, take_done;
    logic [LINE_IDX_W-1:0]   hdr_idx;
    logic [LINE_IDX_W-1:0]   nm_in;
    logic                    rd_accept;
    logic                    rd_oob_now;

    logic                    tbl_we, tbl_clr;
    logic [LINE_IDX_W-1:0]   tbl_waddr;
    index_entry_t            tbl_wdata, rd_entry;

    assign hdr_idx = word_line_idx(word);
    assign nm_in   = {1'b0, n} + {1'b0, m};

    board_index_table #(
        .DEPTH (MAX_LINES)
    ) u_index_table (
        .clk   (clk),
        .rst   (rst),
        .clr   (tbl_clr),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (rd_line),
        .rdata (rd_entry)
    );

    // State and load bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            full_reg     <= 1'b0;
            open_reg     <= 1'b0;
            cur_idx_reg  <= '0;
            cur_base_reg <= '0;
            cur_cnt_reg  <= '0;
            nm_reg       <= '0;
            err_reg      <= 1'b0;
`ifdef LOAD_CHECK_EN
            exp_reg      <= '0;
            seen_reg     <= '0;
            lines_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            full_reg     <= full_next;
            open_reg     <= open_next;
            cur_idx_reg  <= cur_idx_next;
            cur_base_reg <= cur_base_next;
            cur_cnt_reg  <= cur_cnt_next;
            nm_reg       <= nm_next;
            err_reg      <= err_next;
`ifdef LOAD_CHECK_EN
            exp_reg      <= exp_next;
            seen_reg     <= seen_next;
            lines_reg    <= lines_next;
`endif
        end
    end

    // Next-state, table updates and BRAM port control
    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        full_next     = full_reg;
        open_next     = open_reg;
        cur_idx_next  = cur_idx_reg;
        cur_base_next = cur_base_reg;
        cur_cnt_next  = cur_cnt_reg;
        nm_next       = nm_reg;
        err_next      = err_reg;
`ifdef LOAD_CHECK_EN
        exp_next      = exp_reg;
        seen_next     = seen_reg;
        lines_next    = lines_reg;
`endif
        take_header = 1'b0;
        take_option = 1'b0;
        take_done   = 1'b0;
        tbl_we      = 1'b0;
        tbl_clr     = 1'b0;
        tbl_waddr   = cur_idx_reg;
        tbl_wdata   = '0;
        bram_we     = 1'b0;
        bram_addr   = '0;
        bram_din    = '0;
        solve_start = 1'b0;
        rd_ready    = 1'b0;
        rd_accept   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (word_valid && word[WORD_HDR_BIT]) begin
                    // First header of a new board: start from a clean slate
                    state_next  = LOAD;
                    err_next    = 1'b0;
                    full_next   = 1'b0;
                    open_next   = 1'b0;
                    take_header = 1'b1;
`ifdef LOAD_CHECK_EN
                    seen_next   = '0;
                    lines_next  = '0;
                end else if (word_valid) begin
                    err_next    = 1'b1;
`endif
                end
            end
            LOAD: begin
                take_header = word_valid &&  word[WORD_HDR_BIT];
                take_option = word_valid && !word[WORD_HDR_BIT];
                take_done   = board_done;
            end
            ARMED: begin
                solve_start = 1'b1;
                state_next  = SOLVE;
            end
            SOLVE: begin
                rd_ready  = !solve_done;
                rd_accept = rd_req && !solve_done;
                if (rd_accept) begin
                    bram_addr = rd_entry.base + ADDR_W'(rd_opt);
                end
                if (solve_done) begin
                    state_next  = IDLE;
                    wr_ptr_next = '0;
                    tbl_clr     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Header: close the open line, then open the new one at wr_ptr
        if (take_header) begin
`ifdef LOAD_CHECK_EN
            if (open_next && (cur_cnt_next != exp_next)) err_next = 1'b1;
`endif
            if (hdr_idx >= LINES_LIM) begin
                open_next = 1'b0;
                err_next  = 1'b1;
            end else begin
`ifdef LOAD_CHECK_EN
                if (seen_next[hdr_idx]) err_next = 1'b1;
                seen_next[hdr_idx] = 1'b1;
                lines_next = lines_next + LINE_IDX_W'(1);
                exp_next   = CNT_W'(word[WORD_CNT_MSB:0]);
`endif
                open_next      = 1'b1;
                cur_idx_next   = hdr_idx;
                cur_base_next  = wr_ptr_next;
                cur_cnt_next   = '0;
                tbl_we         = 1'b1;
                tbl_waddr      = hdr_idx;
                tbl_wdata.base = wr_ptr_next;
                tbl_wdata.cnt  = '0;
            end
        end

        // Option: append to BRAM unless the line was dropped or BRAM is full
        if (take_option && open_next) begin
            if (full_next) begin
                err_next = 1'b1;
            end else begin
                bram_we        = 1'b1;
                bram_addr      = wr_ptr_next;
                bram_din       = word;
                cur_cnt_next   = cur_cnt_next + CNT_W'(1);
                tbl_we         = 1'b1;
                tbl_waddr      = cur_idx_next;
                tbl_wdata.base = cur_base_next;
                tbl_wdata.cnt  = cur_cnt_next;
                if (wr_ptr_next == '1) begin
                    full_next = 1'b1;
                end else begin
                    wr_ptr_next = wr_ptr_next + ADDR_W'(1);
                end
            end
        end

        // End of board: close the last line and arm the solver
        if (take_done) begin
`ifdef LOAD_CHECK_EN
            if (open_next && (cur_cnt_next != exp_next)) err_next = 1'b1;
            if (lines_next != nm_in) err_next = 1'b1;
`endif
            open_next  = 1'b0;
            nm_next    = nm_in;
            state_next = ARMED;
        end
    end

    assign rd_oob_now = (rd_line >= nm_reg) || (rd_opt >= rd_entry.cnt);

    logic [BRAM_LAT-1:0] vld_pipe_reg;
    logic [BRAM_LAT-1:0] oob_pipe_reg;
    logic [CNT_W-1:0]    cnt_pipe_reg [BRAM_LAT];

    // Read-side metadata delayed to line up with the BRAM data
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_reg <= '0;
            oob_pipe_reg <= '0;
            for (int i = 0; i < BRAM_LAT; i++) cnt_pipe_reg[i] <= '0;
        end else begin
            vld_pipe_reg[0] <= rd_accept;
            oob_pipe_reg[0] <= rd_accept && rd_oob_now;
            cnt_pipe_reg[0] <= rd_accept ? rd_entry.cnt : '0;
            for (int i = 1; i < BRAM_LAT; i++) begin
                vld_pipe_reg[i] <= vld_pipe_reg[i-1];
                oob_pipe_reg[i] <= oob_pipe_reg[i-1];
                cnt_pipe_reg[i] <= cnt_pipe_reg[i-1];
            end
        end
    end

    logic dout_unused;
    assign dout_unused = ^bram_dout[15:BITMAP_W];

    assign rd_valid = vld_pipe_reg[BRAM_LAT-1];
    assign rd_oob   = oob_pipe_reg[BRAM_LAT-1];
    assign rd_count = cnt_pipe_reg[BRAM_LAT-1];
    assign rd_data  = (rd_valid && !rd_oob) ? bram_dout[BITMAP_W-1:0] : '0;
    assign state    = state_reg;
    assign load_err = err_reg;

endmodule

// File: tb/tb_board_load_ctrl.sv
// Directed bench for board_load_ctrl with a 2-cycle BRAM model.
module tb_board_load_ctrl;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 10;
`ifdef LOAD_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              word_valid;
    logic [15:0]       word;
    logic              board_done;
    logic [3:0]        n, m;
    logic [ADDR_W-1:0] bram_addr;
    logic [15:0]       bram_din;
    logic              bram_we;
    logic [15:0]       bram_dout;
    logic              solve_start;
    logic              solve_done;
    logic              rd_req;
    logic [4:0]        rd_line;
    logic [CNT_W-1:0]  rd_opt;
    logic              rd_ready;
    logic              rd_valid;
    logic [10:0]       rd_data;
    logic [CNT_W-1:0]  rd_count;
    logic              rd_oob;
    logic [1:0]        state;
    logic              load_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    board_load_ctrl dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word(word),
        .board_done(board_done), .n(n), .m(m),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .bram_dout(bram_dout), .solve_start(solve_start), .solve_done(solve_done),
        .rd_req(rd_req), .rd_line(rd_line), .rd_opt(rd_opt), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count), .rd_oob(rd_oob),
        .state(state), .load_err(load_err)
    );

    // Single-port BRAM with 2-cycle registered read
    logic [15:0] mem [0:4095];
    logic [15:0] rd_s1, rd_s2;
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        rd_s1 <= mem[bram_addr];
        rd_s2 <= rd_s1;
    end
    assign bram_dout = rd_s2;

    function automatic logic [15:0] hdr(input logic [4:0] idx, input logic [9:0] cnt);
        return {1'b1, idx, cnt};
    endfunction

    function automatic logic [15:0] opt(input logic [10:0] bm);
        return {5'b0, bm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    int          we_cnt;
    logic [31:0] last_addr;

    initial begin
        rst = 1'b1; word_valid = 1'b0; word = '0; board_done = 1'b0; n = '0; m = '0;
        solve_done = 1'b0; rd_req = 1'b0; rd_line = '0; rd_opt = '0;
        we_cnt = 0; last_addr = '0;
        step(); step();
        rst = 1'b0; #1;
        check("rst_state", state, 0);
        check("rst_we", bram_we, 0);
        check("rst_start", solve_start, 0);
        check("rst_ready", rd_ready, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_err", load_err, 0);

        // 4x4 board: L0 {001}, L1 {003, 002}
        word_valid = 1'b1; word = hdr(5'd0, 10'd1); #1;
        check("idle_hdr_we", bram_we, 0);
        step();
        check("load_state", state, 1);
        word = opt(11'h001); #1;
        check("wr0_we", bram_we, 1);
        check("wr0_addr", bram_addr, 0);
        check("wr0_din", bram_din, 16'h0001);
        step();
        word = hdr(5'd1, 10'd2); #1;
        check("hdr1_we", bram_we, 0);
        step();
        word = opt(11'h003); #1;
        check("wr1_addr", bram_addr, 1);
        step();
        word = opt(11'h002); #1;
        check("wr2_addr", bram_addr, 2);
        check("wr2_din", bram_din, 16'h0002);
        step();
        word_valid = 1'b0; board_done = 1'b1; n = 4'd4; m = 4'd4;
        step();
        board_done = 1'b0; #1;
        check("armed_state", state, 2);
        check("armed_start", solve_start, 1);
        step(); #1;
        check("solve_state", state, 3);
        check("solve_start_gone", solve_start, 0);
        check("solve_ready", rd_ready, 1);
        check("board1_err", load_err, CHK);

        // Single read (1,1)
        rd_req = 1'b1; rd_line = 5'd1; rd_opt = 10'd1; #1;
        check("rd11_addr", bram_addr, 2);
        check("rd11_we", bram_we, 0);
        step();
        rd_req = 1'b0; #1;
        check("rd11_lat1_valid", rd_valid, 0);
        step(); #1;
        check("rd11_valid", rd_valid, 1);
        check("rd11_data", rd_data, 11'h002);
        check("rd11_count", rd_count, 2);
        check("rd11_oob", rd_oob, 0);
        step(); #1;
        check("rd11_after", rd_valid, 0);

        // Back-to-back reads (0,0), (1,0), (1,5)
        rd_req = 1'b1; rd_line = 5'd0; rd_opt = 10'd0; #1;
        check("bb0_addr", bram_addr, 0);
        step();
        rd_line = 5'd1; rd_opt = 10'd0; #1;
        check("bb1_addr", bram_addr, 1);
        step();
        rd_line = 5'd1; rd_opt = 10'd5; #1;
        check("bb2_ready", rd_ready, 1);
        check("bb0_valid", rd_valid, 1);
        check("bb0_data", rd_data, 11'h001);
        check("bb0_count", rd_count, 1);
        check("bb0_oob", rd_oob, 0);
        step();
        rd_req = 1'b0; #1;
        check("bb1_valid", rd_valid, 1);
        check("bb1_data", rd_data, 11'h003);
        check("bb1_count", rd_count, 2);
        check("bb1_oob", rd_oob, 0);
        step(); #1;
        check("bb2_valid", rd_valid, 1);
        check("bb2_oob", rd_oob, 1);
        check("bb2_data", rd_data, 0);
        check("bb2_count", rd_count, 2);
        step(); #1;
        check("bb_after", rd_valid, 0);

        // solve_done together with a request: not accepted
        solve_done = 1'b1; rd_req = 1'b1; rd_line = 5'd1; rd_opt = 10'd0; #1;
        check("sd_ready", rd_ready, 0);
        check("sd_addr", bram_addr, 0);
        step();
        solve_done = 1'b0; rd_req = 1'b0; #1;
        check("sd_state", state, 0);
        check("sd_valid1", rd_valid, 0);
        step(); #1;
        check("sd_valid2", rd_valid, 0);

        // New board: header cnt3 with only two options, n=m=1
        word_valid = 1'b1; word = hdr(5'd2, 10'd3);
        step(); #1;
        check("b2_state", state, 1);
        word = opt(11'h7FF); #1;
        check("b2_wr0_addr", bram_addr, 0);
        check("b2_wr0_we", bram_we, 1);
        step();
        word = opt(11'h400); #1;
        check("b2_wr1_addr", bram_addr, 1);
        step();
        word_valid = 1'b0; board_done = 1'b1; n = 4'd1; m = 4'd1;
        step();
        board_done = 1'b0; #1;
        check("b2_err", load_err, CHK);
        step(); #1;
        check("b2_solve", state, 3);
        // line 2 >= n+m: out of bounds even though it holds options
        rd_req = 1'b1; rd_line = 5'd2; rd_opt = 10'd1; #1;
        check("b2_rd_addr", bram_addr, 1);
        step();
        rd_req = 1'b0;
        step(); #1;
        check("b2_rd_valid", rd_valid, 1);
        check("b2_rd_oob", rd_oob, 1);
        check("b2_rd_data", rd_data, 0);
        check("b2_rd_count", rd_count, 2);
        solve_done = 1'b1;
        step();
        solve_done = 1'b0; #1;

        // Bad line index: dropped with its options
        word_valid = 1'b1; word = hdr(5'd25, 10'd1);
        step(); #1;
        check("bad_state", state, 1);
        check("bad_err", load_err, 1);
        word = opt(11'h00F); #1;
        check("bad_opt_we", bram_we, 0);
        step();
        word = hdr(5'd0, 10'd1);
        step();
        word = opt(11'h001); #1;
        check("bad_next_addr", bram_addr, 0);
        check("bad_next_we", bram_we, 1);
        step();
        word_valid = 1'b0; board_done = 1'b1; n = 4'd1; m = 4'd0;
        step();
        board_done = 1'b0;
        step(); #1;
        check("bad_solve", state, 3);
        solve_done = 1'b1;
        step();
        solve_done = 1'b0; #1;
        check("bad_idle", state, 0);
        check("bad_err_sticky", load_err, 1);
        word_valid = 1'b1; word = opt(11'h0F0); #1;
        check("idle_opt_we", bram_we, 0);
        step(); #1;
        check("idle_opt_state", state, 0);
        word = hdr(5'd0, 10'd4);
        step(); #1;
        check("err_cleared", load_err, 0);
        check("reload_state", state, 1);

        // Reset mid-load after two writes, then reload
        word = opt(11'h0AA); #1;
        check("pre_rst_addr0", bram_addr, 0);
        step();
        word = opt(11'h0BB); #1;
        check("pre_rst_addr1", bram_addr, 1);
        step();
        word_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_ready", rd_ready, 0);
        word_valid = 1'b1; word = hdr(5'd0, 10'd1);
        step();
        word = opt(11'h055); #1;
        check("post_rst_addr", bram_addr, 0);
        check("post_rst_din", bram_din, 16'h0055);
        step();

        // Fill the BRAM to the last address, then one more word
        for (int i = 1; i < 4096; i++) begin
            word = opt(11'(i)); #1;
            if (bram_we) begin
                we_cnt++;
                last_addr = 32'(bram_addr);
            end
            step();
        end
        check("full_we_count", we_cnt, 4095);
        check("full_last_addr", last_addr, 4095);
        check("full_err_before", load_err, 0);
        word = opt(11'h001); #1;
        check("full_drop_we", bram_we, 0);
        step();
        word_valid = 1'b0; #1;
        check("full_err", load_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
